// File: rtl/tdc_pkg.sv
// Shared widths, readout word layout and arbiter state encoding for the TDC readout arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

    localparam int TDC_W  = 12;
    localparam int BC_W   = 7;
    localparam int CHID_W = 3;

    // One readout word as it sits in the output buffer: {ch_id, bc_time, tdc}.
    typedef struct packed {
        logic [CHID_W-1:0] ch_id;
        logic [BC_W-1:0]   bc_time;
        logic [TDC_W-1:0]  tdc;
    } tdc_word_t;

    localparam int WORD_W = $bits(tdc_word_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tdc_arb_fifo.sv
// Synchronous output buffer for readout words, with occupancy count, full and empty flags.
// Latency: a word written at a clock edge is visible at the head after that edge (no fall-through).
// Backpressure: writes are ignored when full, reads are ignored when empty.
// Ports: i_clk/i_rst clock and async active-high reset; i_wr_en/i_wr_dat write side;
//        i_rd_en read strobe; o_rd_dat head word (zero while empty); o_count/o_full/o_empty status.
module tdc_arb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 22
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [W-1:0]           i_wr_dat,
    input  logic                   i_rd_en,
    output logic [W-1:0]           o_rd_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;

    // Head is forced to zero while empty so the output is defined out of reset.
    assign o_rd_dat = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tdc_readout_arb.sv
// Round-robin readout arbiter: grants one ready TDC channel, buffers {ch_id, bc_time, tdc} in a FIFO.
// Latency: ch_ack one cycle after ch_rdy is sampled in IDLE; out_valid the cycle after the grant.
// Backpressure: no grant while the FIFO is full; requests stall (never dropped) until out_ready drains it.
// Ports: clk300/reset (async active-high); en grant enable; bc_time sampled at grant;
//        ch_rdy/ch_data per-channel request and value; ch_ack one-hot grant pulse;
//        out_valid/out_ready/out_data buffered output; fifo_full buffer full flag.
// Optional: define TDC_ARB_STATS_EN to add stall_cnt, a saturating count of IDLE cycles
//           blocked only by a full buffer.
module tdc_readout_arb
    import tdc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk300,
    input  logic                         reset,
    input  logic                         en,
    input  logic [BC_W-1:0]              bc_time,
    input  logic [NUM_CH-1:0]            ch_rdy,
    input  logic [NUM_CH-1:0][TDC_W-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_data,
    output logic                         fifo_full
`ifdef TDC_ARB_STATS_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_FULL  = CW'(FIFO_DEPTH);
    localparam int                MAX_CH    = 1 << CHID_W;
    localparam logic [CHID_W-1:0] LAST_INIT = CHID_W'(NUM_CH - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [CHID_W-1:0] r_last;
    logic [CHID_W-1:0] r_grant;
    logic [CHID_W-1:0] w_sel;
    logic [CHID_W-1:0] w_cand;
    logic              w_found;
    logic [MAX_CH-1:0] w_req;
    logic [TDC_W-1:0]  w_tdc;
    tdc_word_t         w_wr_word;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_can_write;

    // Requests padded to the full ch_id range so a ch_id-wide index is always in range.
    always_comb begin
        w_req             = '0;
        w_req[NUM_CH-1:0] = ch_rdy;
    end

    // Round-robin pick: first ready channel searching upward from last_grant+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = CHID_W'((int'(r_last) + i) % NUM_CH);
            if (!w_found && w_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_can_write = (w_count != CNT_FULL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en && w_can_write && w_found) w_next = GRANT;
            GRANT:   w_next = HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk300 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= LAST_INIT;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == GRANT) begin
                r_grant <= w_sel;
            end
            if (r_state == GRANT) begin
                r_last <= r_grant;
            end
        end
    end

    always_comb begin
        ch_ack = '0;
        w_tdc  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack[i] = (r_state == GRANT) && (r_grant == CHID_W'(i));
            if (r_grant == CHID_W'(i)) begin
                w_tdc = ch_data[i];
            end
        end
    end

    always_comb begin
        w_wr_word.ch_id   = r_grant;
        w_wr_word.bc_time = bc_time;
        w_wr_word.tdc     = w_tdc;
    end

    tdc_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .i_clk    (clk300),
        .i_rst    (reset),
        .i_wr_en  (r_state == GRANT),
        .i_wr_dat (w_wr_word),
        .i_rd_en  (out_ready),
        .o_rd_dat (out_data),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    assign out_valid = !w_empty;
    assign fifo_full = w_full;

`ifdef TDC_ARB_STATS_EN
    always_ff @(posedge clk300 or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (r_state == IDLE && en && (|ch_rdy) && w_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_readout_arb.sv
// Directed bench for tdc_readout_arb with a round-robin reference model and an output scoreboard.
module tb_tdc_readout_arb;

    logic             clk300 = 1'b0;
    logic             reset;
    logic             en;
    logic [6:0]       bc_time;
    logic [3:0]       ch_rdy;
    logic [3:0][11:0] ch_data;
    logic [3:0]       ch_ack;
    logic             out_valid;
    logic             out_ready;
    logic [21:0]      out_data;
    logic             fifo_full;
`ifdef TDC_ARB_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk300 = ~clk300;

    tdc_readout_arb #(.NUM_CH(4), .FIFO_DEPTH(8)) dut (
        .clk300    (clk300),
        .reset     (reset),
        .en        (en),
        .bc_time   (bc_time),
        .ch_rdy    (ch_rdy),
        .ch_data   (ch_data),
        .ch_ack    (ch_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_full (fifo_full)
`ifdef TDC_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int          errors = 0;
    int          checks = 0;
    logic [21:0] sb[$];
    logic [3:0]  ack_log[$];
    int          ack_cyc[$];
    int          ack_cnt = 0;
    int          m_last  = 3;
    int          cyc_n   = 0;
    int          mon_e;
    logic        bc_run  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] rdy);
        for (int i = 1; i <= 4; i++) begin
            if (rdy[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk300) cyc_n <= cyc_n + 1;

    initial begin
        forever begin
            @(posedge clk300);
            #1;
            if (bc_run) bc_time = bc_time + 7'd1;
        end
    end

    // Reference: expected grant from the round-robin model, expected word pushed on each grant,
    // popped and compared on each accepted output beat.
    always @(negedge clk300) begin
        if (reset) begin
            sb.delete();
            m_last = 3;
        end else begin
            if (ch_ack != 4'b0) begin
                mon_e = rr_pick(m_last, ch_rdy);
                if (mon_e < 0) begin
                    chk("ack_without_req", 32'(ch_ack), 32'h0);
                end else begin
                    chk("ack_rr", 32'(ch_ack), 32'(1 << mon_e));
                    sb.push_back({3'(mon_e), bc_time, ch_data[mon_e[1:0]]});
                    m_last = mon_e;
                end
                ack_cnt++;
                ack_log.push_back(ch_ack);
                ack_cyc.push_back(cyc_n);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk300);
        #1;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk300);
            if (ch_ack != 4'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk300);
            if (!out_valid) break;
        end
        @(negedge clk300);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_order [5];
        int         base;
        int         base2;
        int         nx;
        logic       found;

        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1; en = 1'b0; out_ready = 1'b0; ch_rdy = '0; ch_data = '0; bc_time = '0;

        // Reset state
        repeat (3) @(negedge clk300);
        chk("rst_ack", 32'(ch_ack), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        drive_edge();
        reset = 1'b0;

        // Single request on channel 0
        drive_edge();
        en = 1'b1; bc_time = 7'd5; ch_data[0] = 12'h0A5; ch_rdy = 4'b0001;
        @(negedge clk300);
        chk("A_ack_idle", 32'(ch_ack), 32'd0);
        @(negedge clk300);
        chk("A_ack", 32'(ch_ack), 32'b0001);
        chk("A_no_fallthrough", 32'(out_valid), 32'd0);
        drive_edge();
        ch_rdy = 4'b0000;
        @(negedge clk300);
        chk("A_valid", 32'(out_valid), 32'd1);
        chk("A_data", 32'(out_data), 32'({3'd0, 7'd5, 12'h0A5}));
        drive_edge();
        out_ready = 1'b1;
        drain("A_drain");

        // All four requesting: order and spacing from reset
        drive_edge();
        reset = 1'b1;
        drive_edge();
        reset = 1'b0;
        ack_log.delete(); ack_cyc.delete();
        bc_run = 1'b1;
        for (int i = 0; i < 4; i++) ch_data[i] = 12'(12'h100 + i * 12'h11);
        ch_rdy = 4'b1111;
        for (int i = 0; i < 5; i++) wait_ack("B_ack_timeout", 12);
        drive_edge();
        ch_rdy = 4'b0000;
        @(negedge clk300);
        for (int i = 0; i < 5; i++) chk($sformatf("B_order%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("B_gap%0d", i), 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
        drain("B_drain");

        // Buffer fills with out_ready low, then resumes
        drive_edge();
        out_ready = 1'b0; ch_rdy = 4'b1111; base = ack_cnt;
        repeat (40) @(negedge clk300);
        chk("C_writes", 32'(ack_cnt - base), 32'd8);
        chk("C_full", 32'(fifo_full), 32'd1);
        base2 = ack_cnt;
        repeat (9) @(negedge clk300);
        chk("C_stalled", 32'(ack_cnt - base2), 32'd0);
        drive_edge();
        out_ready = 1'b1;
        repeat (30) @(negedge clk300);
        chk("C_resumed", 32'(ack_cnt > base2), 32'd1);
        wait_ack("C_ack_timeout", 12);
        drive_edge();
        ch_rdy = 4'b0000;
        drain("C_drain");

        // en drops during GRANT: that grant completes, then no grants while FIFO drains
        drive_edge();
        out_ready = 1'b0; ch_rdy = 4'b1111;
        wait_ack("D_ack_timeout", 12);
        #1 en = 1'b0;
        repeat (3) @(negedge clk300);
        chk("D_word_written", 32'(out_valid), 32'd1);
        base = ack_cnt;
        drive_edge();
        out_ready = 1'b1;
        repeat (20) @(negedge clk300);
        chk("D_no_ack", 32'(ack_cnt - base), 32'd0);
        chk("D_empty", 32'(out_valid), 32'd0);
        chk("D_sb_empty", 32'(sb.size()), 32'd0);
        nx = (m_last + 1) % 4;
        drive_edge();
        en = 1'b1;
        wait_ack("D_resume_timeout", 12);
        chk("D_resume", 32'(ch_ack), 32'(1 << nx));
        drive_edge();
        en = 1'b0; ch_rdy = 4'b0000;
        // Channel after last_grant withdraws before being granted: it is skipped
        drive_edge();
        ch_rdy = 4'b1111;
        repeat (2) drive_edge();
        nx = (m_last + 2) % 4;
        ch_rdy = 4'(1 << nx);
        drive_edge();
        en = 1'b1;
        wait_ack("D_skip_timeout", 12);
        chk("D_skip", 32'(ch_ack), 32'(1 << nx));
        drive_edge();
        ch_rdy = 4'b0000;
        drain("D_drain");

        // Reset during GRANT: outputs clear at once, pending write discarded, channel 0 first
        drive_edge();
        ch_rdy = 4'b0100;
        wait_ack("F_ack_timeout", 12);
        #1 reset = 1'b1;
        #1;
        chk("F_rst_ack", 32'(ch_ack), 32'd0);
        chk("F_rst_valid", 32'(out_valid), 32'd0);
        chk("F_rst_data", 32'(out_data), 32'd0);
        chk("F_rst_full", 32'(fifo_full), 32'd0);
        drive_edge();
        ch_rdy = 4'b0101;
        drive_edge();
        reset = 1'b0;
        wait_ack("F_first_timeout", 12);
        chk("F_first", 32'(ch_ack), 32'b0001);
        drive_edge();
        ch_rdy = 4'b0100;
        wait_ack("F_regrant_timeout", 12);
        chk("F_regrant", 32'(ch_ack), 32'b0100);
        drive_edge();
        ch_rdy = 4'b0000;
        drain("F_drain");

`ifdef TDC_ARB_STATS_EN
        drive_edge();
        reset = 1'b1;
        drive_edge();
        reset = 1'b0; out_ready = 1'b0; en = 1'b1; ch_rdy = 4'b1111;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk300);
            if (fifo_full) begin
                found = 1'b1;
                break;
            end
        end
        #1 en = 1'b0;
        chk("S_full_timeout", 32'(found), 32'd1);
        repeat (3) @(negedge clk300);
        chk("S_zero", 32'(stall_cnt), 32'd0);
        drive_edge();
        en = 1'b1;
        repeat (20) @(posedge clk300);
        #1 en = 1'b0;
        @(negedge clk300);
        chk("S_twenty", 32'(stall_cnt), 32'd20);
        drive_edge();
        en = 1'b1;
        repeat (70000) @(posedge clk300);
        #1 en = 1'b0;
        @(negedge clk300);
        chk("S_saturate", 32'(stall_cnt), 32'hFFFF);
        drive_edge();
        ch_rdy = 4'b0000; out_ready = 1'b1;
        drain("S_drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdc_readout_arb.md
TDC_READOUT_ARB -- requirements
Module: tdc_readout_arb

Interface
REQ-001 Parameter NUM_CH, default 4, number of TDC channels sharing readout (2..8).
REQ-002 Parameter FIFO_DEPTH, default 8, output buffer depth in words (power of two).
REQ-003 clk300  in  1  single clock.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 en  in  1  grant enable; when low, no new grants and the FIFO keeps draining.
REQ-006 bc_time  in  7  bunch-crossing time, sampled at grant.
REQ-007 ch_rdy  in  NUM_CH  per-channel hit ready; each channel holds it until acked.
REQ-008 ch_data  in  NUM_CH x 12  per-channel tdc_out value, stable while ch_rdy is high.
REQ-009 ch_ack  out  NUM_CH  one-hot, one-cycle grant acknowledge.
REQ-010 out_valid  out  1  FIFO head valid.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 out_data  out  3+7+12  {ch_id, bc_time, tdc}; ch_id is zero-extended to 3 bits.
REQ-013 fifo_full  out  1  buffer full flag.

Function
REQ-014 FSM states: IDLE, GRANT, HOLD.
REQ-015 IDLE->GRANT when en=1, fifo not full, and any ch_rdy=1; otherwise stay in IDLE.
REQ-016 Grant selection (in IDLE, registered on the transition): round-robin, searching upward from last_grant+1 modulo NUM_CH.
REQ-017 GRANT: ch_ack[g]=1 for exactly this cycle; FIFO write {g, bc_time, ch_data[g]} at the end of the cycle; last_grant<=g; next state HOLD.
REQ-018 HOLD: one cycle with no ack, giving the channel time to drop ch_rdy; next state IDLE.
REQ-019 Throughput: at most 1 grant per 3 cycles. Latency from ch_rdy sampled in IDLE to ch_ack: 1 cycle.
REQ-020 With the FIFO empty, out_valid rises the cycle after GRANT (no fall-through).
REQ-021 A FIFO read occurs when out_valid && out_ready. Read and write in the same cycle leave the count unchanged.
REQ-022 Full: no grant is issued; requests stall and are never dropped.
REQ-023 If a grant is in flight while count=FIFO_DEPTH-1, the write completes. The fill check happens again in the next IDLE cycle.
REQ-024 A channel deasserting ch_rdy before its grant is simply skipped; the arbiter does not latch requests.
REQ-025 en falling during GRANT or HOLD: the current grant completes, then the FSM stays in IDLE.
REQ-026 last_grant wraps from NUM_CH-1 to 0.

Reset
REQ-027 On reset, asynchronously: state=IDLE, last_grant=NUM_CH-1 (so channel 0 wins first), FIFO empty, ch_ack=0, out_valid=0, out_data=0, fifo_full=0.
REQ-028 Reset asserted mid-GRANT discards the pending write; that channel's request stays pending and is re-granted after reset.

Configuration
REQ-029 Macro TDC_ARB_STATS_EN, when defined, adds output stall_cnt (16 bits). It counts cycles in IDLE with any ch_rdy=1, en=1 and fifo full, saturates at 0xFFFF, and resets to 0.
REQ-030 Without TDC_ARB_STATS_EN, the port and counter are absent and the remaining behaviour is identical.

Structure
REQ-031 Package tdc_pkg holds TDC_W=12, BC_W=7, CHID_W=3, the packed tdc_word_t typedef and the arb_state_t enum.
REQ-032 The buffer is the sub-module tdc_arb_fifo: synchronous FIFO with count, full and empty.

Verification
REQ-033 Reset, then ch_rdy=0001 with ch_data[0]=0x0A5 and bc_time=5:
  - ch_ack=0001 one cycle after IDLE sampling;
  - out_data={0,5,0x0A5}, out_valid rising the following cycle.
REQ-034 All four ch_rdy held high, out_ready=1: grant order 0,1,2,3,0, with a 3-cycle grant spacing.
REQ-035 out_ready=0 and continuous requests:
  - exactly 8 writes, then fifo_full=1 and no ch_ack;
  - release out_ready: grants resume and no word is lost.
REQ-036 en=0 with requests pending: no ch_ack, and the FIFO drains to empty. en=1 resumes grants from last_grant+1.
REQ-037 Assert reset during GRANT:
  - all outputs return to their reset values immediately;
  - after release, channel 0 is granted first.
REQ-038 With TDC_ARB_STATS_EN, full plus 20 stalled cycles gives stall_cnt=20. Forcing 70000 stalled cycles gives stall_cnt=0xFFFF.
